// File: rtl/pipeline_pkg.sv
// Shared types for the pipeline hazard/flow controller: hazard-cause encoding
// and default pipeline register indices.
package pipeline_pkg;

  typedef enum logic [1:0] {
    HZ_NONE     = 2'd0,
    HZ_BUSY     = 2'd1,
    HZ_LOAD_USE = 2'd2,
    HZ_REDIRECT = 2'd3
  } hz_cause_e;

  localparam int IDX_IFID  = 0;
  localparam int IDX_IDEX  = 1;
  localparam int IDX_EXMEM = 2;
  localparam int IDX_MEMWB = 3;

endpackage

// File: rtl/pipeline_ctrl_if.sv
// Hazard-controller bundle between the core (master) and pipeline_ctrl (slave).
// Perf counter signals exist only when PIPELINE_CTRL_PERF_EN is defined.
interface pipeline_ctrl_if #(
  parameter int STAGES    = 4,
  parameter int BUSY_SRCS = 2,
  parameter int RA_W      = 5,
  parameter int CNT_W     = 32
);
  logic                 if_valid;
  logic [RA_W-1:0]      id_rs1, id_rs2;
  logic                 id_uses_rs1, id_uses_rs2;
  logic [RA_W-1:0]      ex_rd;
  logic                 ex_is_load;
  logic [BUSY_SRCS-1:0] busy;
  logic                 redirect;

  logic [STAGES-1:0]    stage_valid, stage_en, stage_flush;
  logic                 pc_en, retire;
  pipeline_pkg::hz_cause_e hz_cause;

`ifdef PIPELINE_CTRL_PERF_EN
  logic                 perf_clr;
  logic [CNT_W-1:0]     perf_cycles, perf_retired, perf_stall_busy, perf_stall_load, perf_flush;
`endif

  if (CNT_W < 1) begin : g_bad_cnt_w
    $error("pipeline_ctrl_if: CNT_W must be at least 1");
  end

  modport master (
    output if_valid, id_rs1, id_rs2, id_uses_rs1, id_uses_rs2, ex_rd, ex_is_load, busy, redirect,
`ifdef PIPELINE_CTRL_PERF_EN
    output perf_clr,
    input  perf_cycles, perf_retired, perf_stall_busy, perf_stall_load, perf_flush,
`endif
    input  stage_valid, stage_en, stage_flush, pc_en, retire, hz_cause
  );

  modport slave (
    input  if_valid, id_rs1, id_rs2, id_uses_rs1, id_uses_rs2, ex_rd, ex_is_load, busy, redirect,
`ifdef PIPELINE_CTRL_PERF_EN
    input  perf_clr,
    output perf_cycles, perf_retired, perf_stall_busy, perf_stall_load, perf_flush,
`endif
    output stage_valid, stage_en, stage_flush, pc_en, retire, hz_cause
  );
endinterface

// File: rtl/pipeline_ctrl_sat_counter.sv
// Saturating event counter with synchronous clear; clear beats increment.
module sat_counter #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc_i,
  input  logic             clr_i,
  output logic [CNT_W-1:0] cnt_o
);
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)                      cnt_d = '0;
    else if (inc_i && cnt_q != '1)  cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;
endmodule

// File: rtl/pipeline_ctrl.sv
// Cause-prioritised pipeline hazard/flow controller (BUSY > REDIRECT > LOAD_USE).
// Define PIPELINE_CTRL_PERF_EN to add five saturating performance counters.
module pipeline_ctrl
  import pipeline_pkg::*;
#(
  parameter int STAGES    = 4,
  parameter int EX_STAGE  = IDX_IDEX,
  parameter int BUSY_SRCS = 2,
  parameter int RA_W      = 5,
  parameter int CNT_W     = 32
) (
  input  logic          clk,
  input  logic          reset,
  pipeline_ctrl_if.slave bus
);

  if (EX_STAGE < 1 || EX_STAGE >= STAGES) begin : g_bad_ex
    $error("pipeline_ctrl: EX_STAGE out of range");
  end
  if (CNT_W < 1) begin : g_bad_cnt
    $error("pipeline_ctrl: CNT_W must be at least 1");
  end

  logic [STAGES-1:0] v_q, v_d, en, flush, shift_in;
  logic              busy_any, redir, load_use, rs1_hit, rs2_hit, pc_en, retire;
  hz_cause_e         cause;

  // A bubble in EX_STAGE can neither redirect nor cause a load-use stall.
  always_comb begin
    busy_any = |bus.busy;
    redir    = bus.redirect & v_q[EX_STAGE];
    rs1_hit  = bus.id_uses_rs1 & (bus.id_rs1 == bus.ex_rd);
    rs2_hit  = bus.id_uses_rs2 & (bus.id_rs2 == bus.ex_rd);
    load_use = v_q[IDX_IFID] & v_q[EX_STAGE] & bus.ex_is_load &
               (bus.ex_rd != '0) & (rs1_hit | rs2_hit);
    if (!reset)        cause = HZ_NONE;
    else if (busy_any) cause = HZ_BUSY;
    else if (redir)    cause = HZ_REDIRECT;
    else if (load_use) cause = HZ_LOAD_USE;
    else               cause = HZ_NONE;
  end

  always_comb begin
    en    = '0;
    flush = '0;
    pc_en = 1'b0;
    if (!reset) begin
      flush = '1;
    end else begin
      case (cause)
        HZ_BUSY: ;
        HZ_REDIRECT: begin
          en    = '1;
          pc_en = 1'b1;
          for (int i = 0; i <= EX_STAGE; i++) flush[i] = 1'b1;
        end
        HZ_LOAD_USE: begin
          for (int i = EX_STAGE; i < STAGES; i++) en[i] = 1'b1;
          flush[EX_STAGE] = 1'b1;
        end
        default: begin
          en    = '1;
          pc_en = 1'b1;
        end
      endcase
    end
  end

  // Enabled registers take their predecessor's valid (or a bubble if flushed).
  assign shift_in = {v_q[STAGES-2:0], bus.if_valid};
  assign v_d      = (en & ~flush & shift_in) | (~en & v_q);
  assign retire   = v_q[STAGES-1] & ~busy_any & reset;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) v_q <= '0;
    else        v_q <= v_d;
  end

  assign bus.stage_valid = v_q;
  assign bus.stage_en    = en;
  assign bus.stage_flush = flush;
  assign bus.pc_en       = pc_en;
  assign bus.retire      = retire;
  assign bus.hz_cause    = cause;

`ifdef PIPELINE_CTRL_PERF_EN
  logic [4:0]            perf_inc;
  logic [4:0][CNT_W-1:0] perf_cnt;

  assign perf_inc = {cause == HZ_REDIRECT, cause == HZ_LOAD_USE, cause == HZ_BUSY, retire, 1'b1};

  for (genvar k = 0; k < 5; k++) begin : g_perf
    sat_counter #(.CNT_W(CNT_W)) u_cnt (
      .clk   (clk),
      .rst_n (reset),
      .inc_i (perf_inc[k]),
      .clr_i (bus.perf_clr),
      .cnt_o (perf_cnt[k])
    );
  end

  assign bus.perf_cycles     = perf_cnt[0];
  assign bus.perf_retired    = perf_cnt[1];
  assign bus.perf_stall_busy = perf_cnt[2];
  assign bus.perf_stall_load = perf_cnt[3];
  assign bus.perf_flush      = perf_cnt[4];
`endif

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Self-checking bench for pipeline_ctrl: hand vector table, directed corner
// sequences and a randomized run against an instruction-tag pipeline model.
module tb_pipeline_ctrl;
  import pipeline_pkg::*;

  localparam int STAGES = 4, EX = 1, BS = 2, RA_W = 5, CNT_W = 4;

  logic clk;
  logic reset;
  int   n_tests = 0;
  int   n_fail  = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  pipeline_ctrl_if #(.STAGES(STAGES), .BUSY_SRCS(BS), .RA_W(RA_W), .CNT_W(CNT_W)) bus ();

  pipeline_ctrl #(.STAGES(STAGES), .EX_STAGE(EX), .BUSY_SRCS(BS), .RA_W(RA_W), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic       ifv, ld, u1, u2, redir;
    logic [4:0] rd, rs1, rs2;
    logic [1:0] busy;
    logic [3:0] sv, en, fl;
    logic       pc, ret;
    logic [1:0] cause;
  } vec_t;

  vec_t tbl[$];
  int   tag[STAGES];
  int   next_tag;

  function automatic vec_t mk(logic ifv, logic ld, logic [4:0] rd, logic [4:0] rs1, logic u1,
                              logic [4:0] rs2, logic u2, logic [1:0] busy, logic redir,
                              logic [3:0] sv, logic [3:0] en, logic [3:0] fl,
                              logic pc, logic ret, logic [1:0] cause);
    vec_t v;
    v.ifv = ifv; v.ld = ld; v.rd = rd; v.rs1 = rs1; v.u1 = u1; v.rs2 = rs2; v.u2 = u2;
    v.busy = busy; v.redir = redir; v.sv = sv; v.en = en; v.fl = fl;
    v.pc = pc; v.ret = ret; v.cause = cause;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic idle();
    bus.if_valid = 1'b0; bus.id_rs1 = '0; bus.id_rs2 = '0;
    bus.id_uses_rs1 = 1'b0; bus.id_uses_rs2 = 1'b0; bus.ex_rd = '0;
    bus.ex_is_load = 1'b0; bus.busy = '0; bus.redirect = 1'b0;
`ifdef PIPELINE_CTRL_PERF_EN
    bus.perf_clr = 1'b0;
`endif
  endtask

  task automatic next_cycle();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic apply_reset();
    reset = 1'b0;
    idle();
    repeat (2) @(negedge clk);
    reset = 1'b1;
    for (int s = 0; s < STAGES; s++) tag[s] = 0;
  endtask

  // Model: each register holds an instruction tag (0 = bubble); one call = one cycle.
  task automatic model_step(input string pfx);
    logic busy_any, exv, redir, lu, e_pc, e_ret;
    logic [1:0] cs;
    logic [STAGES-1:0] e_sv, e_en, e_fl;
    int m;
    busy_any = |bus.busy;
    exv      = (tag[EX] != 0);
    redir    = bus.redirect && exv;
    lu       = (tag[0] != 0) && exv && bus.ex_is_load && (bus.ex_rd != 0) &&
               ((bus.id_uses_rs1 && bus.id_rs1 == bus.ex_rd) ||
                (bus.id_uses_rs2 && bus.id_rs2 == bus.ex_rd));
    cs = busy_any ? 2'd1 : redir ? 2'd3 : lu ? 2'd2 : 2'd0;
    for (int s = 0; s < STAGES; s++) e_sv[s] = (tag[s] != 0);
    case (cs)
      2'd1: begin e_en = '0; e_fl = '0; end
      2'd3: begin m = (1 << (EX + 1)) - 1; e_en = '1; e_fl = m[STAGES-1:0]; end
      2'd2: begin
        m = ((1 << STAGES) - 1) - ((1 << EX) - 1); e_en = m[STAGES-1:0];
        m = 1 << EX; e_fl = m[STAGES-1:0];
      end
      default: begin e_en = '1; e_fl = '0; end
    endcase
    e_pc  = (cs == 2'd0) || (cs == 2'd3);
    e_ret = (tag[STAGES-1] != 0) && !busy_any;
    chk({pfx, ".stage_valid"}, 32'(bus.stage_valid), 32'(e_sv));
    chk({pfx, ".stage_en"},    32'(bus.stage_en),    32'(e_en));
    chk({pfx, ".stage_flush"}, 32'(bus.stage_flush), 32'(e_fl));
    chk({pfx, ".pc_en"},       32'(bus.pc_en),       32'(e_pc));
    chk({pfx, ".retire"},      32'(bus.retire),      32'(e_ret));
    chk({pfx, ".hz_cause"},    32'(bus.hz_cause),    32'(cs));
    case (cs)
      2'd0: begin
        for (int s = STAGES - 1; s > 0; s--) tag[s] = tag[s-1];
        if (bus.if_valid) begin next_tag++; tag[0] = next_tag; end
        else tag[0] = 0;
      end
      2'd3: begin
        for (int s = STAGES - 1; s > EX; s--) tag[s] = tag[s-1];
        for (int s = 0; s <= EX; s++) tag[s] = 0;
      end
      2'd2: begin
        for (int s = STAGES - 1; s > EX; s--) tag[s] = tag[s-1];
        tag[EX] = 0;
      end
      default: ;
    endcase
  endtask

  initial begin
    int first, cnt;
    reset = 1'b1;
    next_tag = 0;
    idle();
    #1 reset = 1'b0;

    // ifv ld rd rs1 u1 rs2 u2 busy redir | sv en fl pc ret cause
    tbl.push_back(mk(1'b1,1'b0,5'd0,5'd0,1'b0,5'd0,1'b0,2'b00,1'b0, 4'b0000,4'b1111,4'b0000,1'b1,1'b0,2'd0));
    tbl.push_back(mk(1'b1,1'b1,5'd5,5'd0,1'b0,5'd5,1'b1,2'b00,1'b0, 4'b0001,4'b1111,4'b0000,1'b1,1'b0,2'd0));
    tbl.push_back(mk(1'b1,1'b1,5'd5,5'd0,1'b0,5'd5,1'b1,2'b00,1'b0, 4'b0011,4'b1110,4'b0010,1'b0,1'b0,2'd2));
    tbl.push_back(mk(1'b1,1'b0,5'd5,5'd0,1'b0,5'd5,1'b1,2'b00,1'b0, 4'b0101,4'b1111,4'b0000,1'b1,1'b0,2'd0));
    tbl.push_back(mk(1'b1,1'b1,5'd0,5'd0,1'b1,5'd0,1'b1,2'b00,1'b0, 4'b1011,4'b1111,4'b0000,1'b1,1'b1,2'd0));
    tbl.push_back(mk(1'b1,1'b0,5'd0,5'd0,1'b0,5'd0,1'b0,2'b00,1'b1, 4'b0111,4'b1111,4'b0011,1'b1,1'b0,2'd3));
    tbl.push_back(mk(1'b1,1'b0,5'd0,5'd0,1'b0,5'd0,1'b0,2'b00,1'b1, 4'b1100,4'b1111,4'b0000,1'b1,1'b1,2'd0));
    tbl.push_back(mk(1'b1,1'b0,5'd0,5'd0,1'b0,5'd0,1'b0,2'b01,1'b0, 4'b1001,4'b0000,4'b0000,1'b0,1'b0,2'd1));
    tbl.push_back(mk(1'b1,1'b0,5'd0,5'd0,1'b0,5'd0,1'b0,2'b10,1'b1, 4'b1001,4'b0000,4'b0000,1'b0,1'b0,2'd1));
    tbl.push_back(mk(1'b0,1'b0,5'd0,5'd0,1'b0,5'd0,1'b0,2'b00,1'b0, 4'b1001,4'b1111,4'b0000,1'b1,1'b1,2'd0));
    tbl.push_back(mk(1'b0,1'b0,5'd0,5'd0,1'b0,5'd0,1'b0,2'b00,1'b0, 4'b0010,4'b1111,4'b0000,1'b1,1'b0,2'd0));
    tbl.push_back(mk(1'b0,1'b0,5'd0,5'd0,1'b0,5'd0,1'b0,2'b11,1'b1, 4'b0100,4'b0000,4'b0000,1'b0,1'b0,2'd1));
    tbl.push_back(mk(1'b0,1'b1,5'd3,5'd3,1'b1,5'd0,1'b0,2'b00,1'b0, 4'b0100,4'b1111,4'b0000,1'b1,1'b0,2'd0));

    // Reset state while held low, even with busy/redirect asserted.
    bus.busy = 2'b01; bus.redirect = 1'b1;
    @(negedge clk); #1;
    chk("rst.stage_valid", 32'(bus.stage_valid), 32'h0);
    chk("rst.stage_en",    32'(bus.stage_en),    32'h0);
    chk("rst.stage_flush", 32'(bus.stage_flush), 32'hF);
    chk("rst.pc_en",       32'(bus.pc_en),       32'h0);
    chk("rst.hz_cause",    32'(bus.hz_cause),    32'h0);

    // Vector table.
    apply_reset();
    foreach (tbl[k]) begin
      bus.if_valid = tbl[k].ifv; bus.ex_is_load = tbl[k].ld; bus.ex_rd = tbl[k].rd;
      bus.id_rs1 = tbl[k].rs1; bus.id_uses_rs1 = tbl[k].u1;
      bus.id_rs2 = tbl[k].rs2; bus.id_uses_rs2 = tbl[k].u2;
      bus.busy = tbl[k].busy; bus.redirect = tbl[k].redir;
      #1;
      chk($sformatf("vec%0d.stage_valid", k), 32'(bus.stage_valid), 32'(tbl[k].sv));
      chk($sformatf("vec%0d.stage_en", k),    32'(bus.stage_en),    32'(tbl[k].en));
      chk($sformatf("vec%0d.stage_flush", k), 32'(bus.stage_flush), 32'(tbl[k].fl));
      chk($sformatf("vec%0d.pc_en", k),       32'(bus.pc_en),       32'(tbl[k].pc));
      chk($sformatf("vec%0d.retire", k),      32'(bus.retire),      32'(tbl[k].ret));
      chk($sformatf("vec%0d.hz_cause", k),    32'(bus.hz_cause),    32'(tbl[k].cause));
      next_cycle();
    end

    // Stream of 10 hazard-free instructions.
    apply_reset();
    first = -1; cnt = 0;
    for (int c = 0; c < 25; c++) begin
      bus.if_valid = (c < 10);
      #1;
      if (bus.retire) begin
        cnt++;
        if (first < 0) first = c;
      end
      next_cycle();
    end
    chk("stream.first_retire", 32'(first), 32'd4);
    chk("stream.retire_count", 32'(cnt), 32'd10);

    // Busy for 6 cycles with a redirect and a load-use both pending.
    apply_reset();
    bus.if_valid = 1'b1;
    next_cycle(); next_cycle();
    bus.ex_is_load = 1'b1; bus.ex_rd = 5'd5; bus.id_rs2 = 5'd5; bus.id_uses_rs2 = 1'b1;
    bus.redirect = 1'b1; bus.busy = 2'b01;
    for (int c = 0; c < 6; c++) begin
      #1;
      chk($sformatf("busy%0d.stage_en", c),    32'(bus.stage_en),    32'h0);
      chk($sformatf("busy%0d.retire", c),      32'(bus.retire),      32'h0);
      chk($sformatf("busy%0d.stage_valid", c), 32'(bus.stage_valid), 32'h3);
      next_cycle();
    end
    bus.busy = 2'b00;
    #1;
    chk("busy_end.hz_cause",    32'(bus.hz_cause),    32'd3);
    chk("busy_end.stage_flush", 32'(bus.stage_flush), 32'h3);
    chk("busy_end.pc_en",       32'(bus.pc_en),       32'h1);
    next_cycle();
    bus.redirect = 1'b0;
    #1;
    chk("busy_post.stage_valid", 32'(bus.stage_valid), 32'h4);
    chk("busy_post.hz_cause",    32'(bus.hz_cause),    32'd0);

    // Asynchronous reset mid-stream, then refill.
    apply_reset();
    bus.if_valid = 1'b1;
    repeat (4) next_cycle();
    #1 chk("midrst.full", 32'(bus.stage_valid), 32'hF);
    bus.busy = 2'b01; bus.redirect = 1'b1;
    #1 reset = 1'b0;
    #1;
    chk("midrst.stage_valid", 32'(bus.stage_valid), 32'h0);
    chk("midrst.stage_en",    32'(bus.stage_en),    32'h0);
    chk("midrst.stage_flush", 32'(bus.stage_flush), 32'hF);
    chk("midrst.retire",      32'(bus.retire),      32'h0);
    @(negedge clk);
    idle();
    reset = 1'b1;
    bus.if_valid = 1'b1;
    next_cycle();
    bus.if_valid = 1'b0;
    first = -1;
    for (int c = 1; c <= 10 && first < 0; c++) begin
      #1;
      if (bus.retire) first = c;
      next_cycle();
    end
    chk("midrst.refill_latency", 32'(first), 32'd4);

    // Randomized run against the tag model.
    apply_reset();
    for (int c = 0; c < 400; c++) begin
      bus.if_valid    = ($urandom_range(3) != 0);
      bus.id_rs1      = 5'($urandom_range(3));
      bus.id_rs2      = 5'($urandom_range(3));
      bus.id_uses_rs1 = ($urandom_range(1) != 0);
      bus.id_uses_rs2 = ($urandom_range(1) != 0);
      bus.ex_rd       = 5'($urandom_range(3));
      bus.ex_is_load  = ($urandom_range(2) == 0);
      bus.busy        = ($urandom_range(7) == 0) ? 2'($urandom_range(3, 1)) : 2'b00;
      bus.redirect    = ($urandom_range(7) == 0);
      #1;
      model_step($sformatf("rnd%0d", c));
      next_cycle();
    end

`ifdef PIPELINE_CTRL_PERF_EN
    apply_reset();
    repeat (20) next_cycle();
    #1;
    chk("perf.cycles_sat", 32'(bus.perf_cycles),     32'd15);
    chk("perf.retired",    32'(bus.perf_retired),    32'd0);
    chk("perf.stall_busy", 32'(bus.perf_stall_busy), 32'd0);
    bus.perf_clr = 1'b1;
    next_cycle();
    bus.perf_clr = 1'b0;
    #1 chk("perf.cycles_clr", 32'(bus.perf_cycles), 32'd0);
    bus.busy = 2'b10;
    repeat (3) next_cycle();
    bus.busy = 2'b00;
    #1;
    chk("perf.stall_busy3", 32'(bus.perf_stall_busy), 32'd3);
    chk("perf.cycles3",     32'(bus.perf_cycles),     32'd3);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/pipeline_ctrl.md
# pipeline_ctrl

Parametrised pipeline hazard and flow controller for the in-order RISC core. Tracks a valid bit per pipeline register and produces per-register advance and flush enables, the PC enable and a retire pulse. It replaces the single global stall/flush pair with a cause-prioritised scheme: multi-cycle unit freeze, load-use bubble insertion, and control-flow redirect. It sits beside the datapath at core top level, driven by decode, execute and the multi-cycle units.

## Interface
- `STAGES`, 4: number of pipeline registers; index 0 = IF/ID, STAGES-1 = MEM/WB.
- `EX_STAGE`, 1: index of the register feeding execute (ID/EX); 1 ≤ EX_STAGE < STAGES.
- `BUSY_SRCS`, 2: number of multi-cycle busy inputs (divider, data memory).
- `RA_W`, 5: register address width.
- `CNT_W`, 32: performance counter width.

- `clk` in 1: clock, rising edge.
- `reset` in 1: reset, asynchronous, active-low.
- `if_valid` in 1: fetch presents an instruction this cycle.
- `id_rs1`, `id_rs2` in RA_W: source addresses of the instruction in register 0.
- `id_uses_rs1`, `id_uses_rs2` in 1: the corresponding source is read.
- `ex_rd` in RA_W: destination of the instruction in register EX_STAGE.
- `ex_is_load` in 1: the instruction in register EX_STAGE is a load.
- `busy` in BUSY_SRCS: per-unit busy; any bit set freezes the pipe.
- `redirect` in 1: taken branch or jump resolved in execute.
- `perf_clr` in 1: synchronous clear of perf counters (macro only).
- `stage_valid` out STAGES: valid bit of each pipeline register.
- `stage_en` out STAGES: register i loads its new value this edge.
- `stage_flush` out STAGES: register i loads a bubble this edge.
- `pc_en` out 1: PC updates this edge.
- `retire` out 1: the valid instruction in register STAGES-1 leaves this cycle.
- `hz_cause` out 2: current cause, NONE=0, BUSY=1, LOAD_USE=2, REDIRECT=3.
- `perf_cycles`, `perf_retired`, `perf_stall_busy`, `perf_stall_load`, `perf_flush` out CNT_W each (macro only).

## Operation
- The only state is `v[STAGES-1:0]` (plus the counters). All other outputs are combinational from state and inputs.
- Qualified events:
  - busy_any = |busy.
  - redir = redirect & v[EX_STAGE].
  - load_use = v[0] & v[EX_STAGE] & ex_is_load & ex_rd≠0 & ((id_uses_rs1 & id_rs1==ex_rd) | (id_uses_rs2 & id_rs2==ex_rd)).
- Cause priority is BUSY > REDIRECT > LOAD_USE > NONE. The selected cause is output on `hz_cause`.
- BUSY:
  - stage_en = 0, stage_flush = 0, pc_en = 0.
  - v holds and retire = 0.
  - Redirect and load-use are not lost: their sources hold while frozen and are re-evaluated when busy drops.
- REDIRECT:
  - Registers 0..EX_STAGE have flush=1 and en=1, and load valid 0.
  - Registers above EX_STAGE advance.
  - pc_en = 1 (fetch loads the target).
- LOAD_USE:
  - Register 0 holds (en=0) and pc_en = 0.
  - Register EX_STAGE is flushed (bubble).
  - Registers above EX_STAGE advance.
  - Registers strictly between 0 and EX_STAGE hold.
- NONE:
  - All registers have en=1, flush=0, and pc_en = 1.
  - v[0] ← if_valid; v[i] ← v[i-1].
- Flushed registers take v=0. Held registers keep v.
- retire = v[STAGES-1] & ~busy_any.
- A bubble (v=0) in register EX_STAGE never triggers a redirect or a load-use stall.

## Timing
- Reset (reset=0), asynchronous:
  - v = 0 and counters = 0.
  - While held in reset: stage_en = 0, stage_flush = all ones, pc_en = 0, retire = 0, hz_cause = 0.
- Redirect asserted in cycle n: at edge n+1, registers 0..EX_STAGE are invalid and the fetch target is in the PC. The first target instruction is valid in register 0 after edge n+2.
- Load-use costs exactly one bubble cycle; the consumer sits in EX_STAGE one cycle after the load leaves it.
- Busy for k cycles costs k cycles; on the first cycle busy=0, behaviour is as if busy had never been asserted.
- Reset released mid-stream: the pipe restarts empty and the first instruction retires STAGES cycles after it enters register 0.

## Configuration
- `PIPELINE_CTRL_PERF_EN` defined — five saturating counters exist; on each edge, unless perf_clr:
  - perf_cycles +1 every cycle.
  - perf_retired +1 on retire.
  - perf_stall_busy +1 per BUSY cycle.
  - perf_stall_load +1 per LOAD_USE cycle.
  - perf_flush +1 per REDIRECT cycle.
- Counters stick at 2^CNT_W−1. perf_clr wins over increment.
- Undefined: the perf ports and `perf_clr` are absent and no counter logic is generated.

## Structure
- `pipeline_pkg` holds the hz_cause typedef and encodings, plus default stage indices (IDX_IFID=0, IDX_IDEX=1, IDX_EXMEM=2, IDX_MEMWB=3).
- One sub-module, `sat_counter` (width CNT_W, inc, clr), instantiated five times under the macro.

## Test plan
- Stream of 10 independent instructions, no hazards → first retire 4 cycles after the first if_valid, then retire every cycle; 10 retires total.
- Load with rd=5 in EX, consumer in ID with rs2=5 → one cycle with hz_cause=2, stage_en=4'b1110, stage_flush=4'b0010, pc_en=0; consumer executes next cycle. Repeat with rd=0 → no stall.
- redirect=1 with v[1]=1 → stage_flush=4'b0011, pc_en=1; next cycle v[1:0]=0. Redirect with v[1]=0 → ignored.
- busy=2'b01 for 6 cycles while a redirect and a load-use are pending → 6 cycles with stage_en=0 and retire=0, then redirect is handled (load-use discarded by the flush).
- reset driven low mid-stream with 4 valid stages → v=0 immediately (asynchronous), without waiting for a clock edge; after release the pipe refills.
- PERF_EN with CNT_W=4: 20 NONE cycles → perf_cycles=15 (saturated); perf_clr for 1 cycle → 0.
